// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with double-buffered hex value and anode guard interval.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_ctrl #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned GUARD    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value_in,
    output logic                  pending,
    output logic [3:0]            bin_out,
    input  logic [6:0]            seg_in,
    output logic [6:0]            seg_out,
    output logic [DIGITS-1:0]     an_out,
    output logic                  frame_done
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = $clog2(DIGITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [CW-1:0]          cnt, cnt_nxt;
    logic [IW-1:0]          idx, idx_nxt;
    logic [DIGITS-1:0][3:0] shadow, shadow_nxt;
    logic [DIGITS-1:0][3:0] active, active_nxt;
    logic                   pending_nxt;
    logic                   tick;
    logic                   boundary;
    logic [DIGITS-1:0]      lit;
    logic [DIGITS-1:0]      an_nxt;

    always_comb begin
        tick     = (cnt == CNT_LAST);
        boundary = tick && (idx == IDX_LAST);
        cnt_nxt  = tick ? '0 : cnt + 1'b1;
        idx_nxt  = idx;
        if (tick) begin
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end

        shadow_nxt  = shadow;
        active_nxt  = active;
        pending_nxt = pending;
        if (load) begin
            shadow_nxt  = value_in;
            pending_nxt = 1'b1;
        end
        // A load on the boundary bypasses the shadow so it is shown in the frame starting now.
        if (boundary) begin
            pending_nxt = 1'b0;
            if (load) begin
                active_nxt = value_in;
            end else if (pending) begin
                active_nxt = shadow;
            end
        end
    end

`ifdef SEG_LZB_EN
    always_comb begin
        logic upper_nz;
        lit      = '0;
        lit[0]   = 1'b1;
        upper_nz = 1'b0;
        for (int unsigned k = 1; k < DIGITS; k++) begin
            upper_nz            = upper_nz | (active_nxt[DIGITS-k] != 4'h0);
            lit[DIGITS-k]       = upper_nz;
        end
    end
`else
    always_comb begin
        lit = '1;
    end
`endif

    // Anodes are registered from next-state so the pins change glitch-free on the slot edge.
    always_comb begin
        an_nxt = '1;
        if ((cnt_nxt >= CNT_GUARD) && lit[idx_nxt]) begin
            an_nxt[idx_nxt] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            shadow     <= '0;
            active     <= '0;
            pending    <= 1'b0;
            bin_out    <= '0;
            seg_out    <= 7'h7F;
            an_out     <= '1;
            frame_done <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            shadow     <= shadow_nxt;
            active     <= active_nxt;
            pending    <= pending_nxt;
            bin_out    <= active_nxt[idx_nxt];
            seg_out    <= seg_in;
            an_out     <= an_nxt;
            frame_done <= boundary;
        end
    end

endmodule
